// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a 16-bit SRAM bus interface, with fixed m0 priority on ties.
// Define SRAM_ARB_ROUND_ROBIN_EN to resolve ties in favour of the master that did not own the bus last.
module sram_arbiter #(
    parameter int ADR_W = 19
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [15:0]      m0_dat_i,
    input  logic [1:0]       m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic             m0_ack_o,
    output logic [15:0]      m0_dat_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [15:0]      m1_dat_i,
    input  logic [1:0]       m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic             m1_ack_o,
    output logic [15:0]      m1_dat_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [15:0]      s_dat_o,
    output logic [1:0]       s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic             s_ack_i,
    input  logic [15:0]      s_dat_i,
    output logic [1:0]       gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end
`else
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    // An owner always falls back to IDLE before the other master can be granted.
    always_comb begin
        state_d = state_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    state_d = last_owner_q ? OWN0 : OWN1;
`else
                    state_d = OWN0;
`endif
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: if (!m0_cyc_i) state_d = IDLE;
            OWN1: if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (state_q == IDLE && state_d == OWN0) last_owner_d = 1'b0;
        if (state_q == IDLE && state_d == OWN1) last_owner_d = 1'b1;
`endif
    end

    // Slave request and master responses follow the current owner with no added latency.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        gnt_o    = 2'b00;
        case (state_q)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                gnt_o    = 2'b01;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

endmodule
